// File: rtl/mux_scan.sv
// mux_scan: registered N-way data selector with a manual select mode and an
// automatic round-robin scan mode that dwells a fixed number of cycles on each
// channel. The Hold input freezes the whole block. Valid pulses on the first
// cycle F carries data from a newly selected channel. Err pulses when a manual
// load names a channel that does not exist.
module mux_scan #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 3,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] In,
  input  logic [SELW-1:0]           S,
  input  logic                      Load,
  input  logic                      Mode,
  input  logic                      Hold,
  output logic [WIDTH-1:0]          F,
  output logic [SELW-1:0]           Ch,
  output logic                      Valid,
  output logic                      Err
);

  // The dwell counter must hold DWELL-1 and is never narrower than the select.
  localparam int DW = $clog2(DWELL + 1);
  localparam int CW = (DW > SELW) ? DW : SELW;

  localparam logic [SELW-1:0] CH_LAST  = SELW'(CHANNELS - 1);
  localparam logic [SELW:0]   CH_LIM   = (SELW + 1)'(CHANNELS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [SELW-1:0]   ch_q, ch_nx;
  logic [CW-1:0]     cnt_q, cnt_nx;
  logic              valid_q, valid_nx;
  logic              err_q, err_nx;
  logic [WIDTH-1:0]  f_q, f_nx;

  // Control state register: mode, channel, dwell count and the two pulses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= MANUAL;
      ch_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      ch_q    <= ch_nx;
      cnt_q   <= cnt_nx;
      valid_q <= valid_nx;
      err_q   <= err_nx;
    end
  end

  // Next-state logic. The registered state decides how this edge behaves, so
  // the edge that enters SCAN only clears the counter and counting starts on
  // the following edge; the edge that leaves SCAN neither counts nor loads.
  always_comb begin
    state_nx = state;
    ch_nx    = ch_q;
    cnt_nx   = cnt_q;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    if (!Hold) begin
      state_nx = Mode ? SCAN : MANUAL;
      cnt_nx   = '0;
      if (state == MANUAL) begin
        if (Load) begin
          if ({1'b0, S} < CH_LIM) begin
            ch_nx    = S;
            valid_nx = (S != ch_q);
          end else begin
            err_nx = 1'b1;
          end
        end
      end else if (Mode) begin
        if (cnt_q == CNT_LAST) begin
          ch_nx    = (ch_q == CH_LAST) ? '0 : ch_q + SELW'(1);
          valid_nx = 1'b1;
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end
    end
  end

  // Output data select: F follows the channel that is in effect after the edge.
  always_comb begin
    f_nx = f_q;
    if (!Hold) begin
      f_nx = '0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (ch_nx == SELW'(k)) begin
          f_nx = In[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Output data register; cleared by reset so F shows 0 until the first edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      f_q <= '0;
    end else begin
      f_q <= f_nx;
    end
  end

  assign F     = f_q;
  assign Ch    = ch_q;
  assign Valid = valid_q;
  assign Err   = err_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan. Instance A: 4 channels, DWELL=3. Instance B:
// 3 channels, DWELL=2 (non-power-of-two wrap and illegal select).
module tb_mux_scan;

  logic        clk;
  logic        rst_a, mode_a, load_a, hold_a;
  logic [1:0]  s_a;
  logic [31:0] in_a;
  logic [7:0]  f_a;
  logic [1:0]  ch_a;
  logic        valid_a, err_a;

  logic        rst_b, mode_b, load_b, hold_b;
  logic [1:0]  s_b;
  logic [23:0] in_b;
  logic [7:0]  f_b;
  logic [1:0]  ch_b;
  logic        valid_b, err_b;

  int n_asrt;
  int n_fail;

  mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut_a (
    .Clock(clk), .Reset(rst_a), .In(in_a), .S(s_a), .Load(load_a),
    .Mode(mode_a), .Hold(hold_a), .F(f_a), .Ch(ch_a), .Valid(valid_a),
    .Err(err_a)
  );

  mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut_b (
    .Clock(clk), .Reset(rst_b), .In(in_b), .S(s_b), .Load(load_b),
    .Mode(mode_b), .Hold(hold_b), .F(f_b), .Ch(ch_b), .Valid(valid_b),
    .Err(err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_ch_b [8];
  logic       exp_v_b  [8];
  logic [7:0] exp_f_b  [8];

  initial begin
    n_asrt = 0;
    n_fail = 0;
    rst_a = 1'b1; mode_a = 1'b0; load_a = 1'b0; hold_a = 1'b0; s_a = 2'd0;
    in_a  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    rst_b = 1'b1; mode_b = 1'b1; load_b = 1'b0; hold_b = 1'b0; s_b = 2'd0;
    in_b  = {8'h33, 8'h22, 8'h11};
    exp_ch_b = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
    exp_v_b  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_f_b  = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h11, 8'h11};

    // Reset state
    #2;
    chk("reset_f",     32'(f_a),     32'h0);
    chk("reset_ch",    32'(ch_a),    32'h0);
    chk("reset_valid", 32'(valid_a), 32'h0);
    chk("reset_err",   32'(err_a),   32'h0);

    // First edge after reset is a normal cycle with no Valid
    tick();
    rst_a = 1'b0;
    tick();
    chk("post_reset_f",     32'(f_a),     32'hA0);
    chk("post_reset_valid", 32'(valid_a), 32'h0);

    // Manual select of channel 2
    load_a = 1'b1; s_a = 2'd2;
    tick();
    chk("man_ch",    32'(ch_a),    32'h2);
    chk("man_f",     32'(f_a),     32'hC2);
    chk("man_valid", 32'(valid_a), 32'h1);
    load_a = 1'b0;
    tick();
    chk("man_valid_drop", 32'(valid_a), 32'h0);
    chk("man_f_keep",     32'(f_a),     32'hC2);

    // Enter scan, let the counter reach 1, then hold for 5 cycles
    mode_a = 1'b1;
    tick();
    chk("scan_entry_ch",    32'(ch_a),    32'h2);
    chk("scan_entry_valid", 32'(valid_a), 32'h0);
    tick();
    hold_a = 1'b1;
    in_a[23:16] = 8'h5C;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ch",    32'(ch_a),    32'h2);
      chk("hold_f",     32'(f_a),     32'hC2);
      chk("hold_valid", 32'(valid_a), 32'h0);
    end
    hold_a = 1'b0;
    tick();
    chk("unhold1_ch",    32'(ch_a),    32'h2);
    chk("unhold1_f",     32'(f_a),     32'h5C);
    chk("unhold1_valid", 32'(valid_a), 32'h0);
    in_a[23:16] = 8'hC2;
    tick();
    chk("unhold2_ch",    32'(ch_a),    32'h3);
    chk("unhold2_f",     32'(f_a),     32'hD3);
    chk("unhold2_valid", 32'(valid_a), 32'h1);

    // Continue scanning: 3 -> 0 wrap, then 0 -> 1
    tick();
    chk("dwell_valid_drop", 32'(valid_a), 32'h0);
    tick();
    tick();
    chk("wrap4_ch",    32'(ch_a),    32'h0);
    chk("wrap4_f",     32'(f_a),     32'hA0);
    chk("wrap4_valid", 32'(valid_a), 32'h1);
    tick();
    tick();
    chk("pre_adv_ch", 32'(ch_a), 32'h0);
    tick();
    chk("adv1_ch", 32'(ch_a), 32'h1);
    chk("adv1_f",  32'(f_a),  32'hB1);

    // Scan -> manual keeps channel 1; reloading 1 gives no Valid
    mode_a = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("manual_stay_ch",    32'(ch_a),    32'h1);
    chk("manual_stay_valid", 32'(valid_a), 32'h0);
    load_a = 1'b1; s_a = 2'd1;
    tick();
    chk("reload_same_ch",    32'(ch_a),    32'h1);
    chk("reload_same_valid", 32'(valid_a), 32'h0);
    chk("reload_same_err",   32'(err_a),   32'h0);

    // Load channel 2 while entering scan, then async reset mid-dwell
    s_a = 2'd2; mode_a = 1'b1;
    tick();
    chk("load_scan_ch",    32'(ch_a),    32'h2);
    chk("load_scan_valid", 32'(valid_a), 32'h1);
    load_a = 1'b0;
    tick();
    #2;
    rst_a = 1'b1;
    #1;
    chk("async_f",     32'(f_a),     32'h0);
    chk("async_ch",    32'(ch_a),    32'h0);
    chk("async_valid", 32'(valid_a), 32'h0);
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_scan_ch0", 32'(ch_a), 32'h0);
      chk("rst_scan_f0",  32'(f_a),  32'hA0);
    end
    tick();
    chk("rst_scan_adv_ch",    32'(ch_a),    32'h1);
    chk("rst_scan_adv_valid", 32'(valid_a), 32'h1);

    // Instance B: scan from reset on 3 channels, DWELL=2, with an ignored illegal load
    tick();
    rst_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("scan3_ch",    32'(ch_b),    32'(exp_ch_b[i]));
      chk("scan3_valid", 32'(valid_b), 32'(exp_v_b[i]));
      chk("scan3_f",     32'(f_b),     32'(exp_f_b[i]));
      chk("scan3_err",   32'(err_b),   32'h0);
      load_b = 1'b1; s_b = 2'd3;
    end

    // Back to manual, select 2, then request illegal channel 3
    load_b = 1'b0; mode_b = 1'b0;
    tick();
    chk("b_manual_ch", 32'(ch_b), 32'h0);
    load_b = 1'b1; s_b = 2'd2;
    tick();
    chk("b_sel_ch",    32'(ch_b),    32'h2);
    chk("b_sel_valid", 32'(valid_b), 32'h1);
    s_b = 2'd3;
    tick();
    chk("illegal_ch",    32'(ch_b),    32'h2);
    chk("illegal_err",   32'(err_b),   32'h1);
    chk("illegal_f",     32'(f_b),     32'h33);
    chk("illegal_valid", 32'(valid_b), 32'h0);
    load_b = 1'b0;
    tick();
    chk("illegal_err_drop", 32'(err_b), 32'h0);
    chk("illegal_ch_keep",  32'(ch_b),  32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
